// File: rtl/dds_channel_pkg.sv
// Shared widths, constants and the gain/offset/saturation datapath for the DDS playback channel.
package dds_channel_pkg;

   localparam int unsigned DATA_W     = 12;
   localparam int unsigned ADDR_W     = 8;
   localparam int unsigned DEPTH      = 1 << ADDR_W;
   localparam int unsigned GAIN_W     = 8;
   localparam int unsigned OFFS_W     = 13;
   localparam int unsigned GAIN_UNITY = 128;
   localparam int unsigned GAIN_SHIFT = 7;
   localparam int unsigned MIDSCALE   = 2048;
   localparam int unsigned DATA_MAX   = (1 << DATA_W) - 1;
   localparam int unsigned PROD_W     = 21;
   localparam int unsigned SUM_W      = 22;

   localparam logic [DATA_W-1:0] MID_CODE = DATA_W'(MIDSCALE);

   // Offset-binary sample -> signed, scale by gain/128, add DC offset, back to offset-binary, clamp.
   function automatic logic [DATA_W-1:0] scale_sample(input logic [DATA_W-1:0]        data,
                                                      input logic [GAIN_W-1:0]        gain,
                                                      input logic signed [OFFS_W-1:0] offset);
      logic signed [DATA_W:0]   s;
      logic signed [PROD_W-1:0] p;
      logic signed [PROD_W-1:0] q;
      logic signed [SUM_W-1:0]  r;
      s = $signed({1'b0, data}) - $signed((DATA_W+1)'(MIDSCALE));
      p = PROD_W'(s) * PROD_W'($signed({1'b0, gain}));
      q = p >>> GAIN_SHIFT;
      r = SUM_W'(q) + SUM_W'(offset) + $signed(SUM_W'(MIDSCALE));
      if (r[SUM_W-1])
         scale_sample = '0;
      else if (r > $signed(SUM_W'(DATA_MAX)))
         scale_sample = DATA_W'(DATA_MAX);
      else
         scale_sample = r[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/dds_channel_if.sv
// Control, waveform-write and DAC-output signals of one DDS channel.
import dds_channel_pkg::*;

interface dds_channel_if;
   logic                     en_i;
   logic                     wc_tick_i;
   logic [ADDR_W-1:0]        len_i;
   logic [GAIN_W-1:0]        gain_i;
   logic signed [OFFS_W-1:0] offset_i;
   logic                     wr_en_i;
   logic [ADDR_W-1:0]        wr_addr_i;
   logic [DATA_W-1:0]        wr_data_i;
   logic [DATA_W-1:0]        dds_o;
   logic                     sample_vld_o;
   logic                     wrap_o;

   modport master (
      output en_i, wc_tick_i, len_i, gain_i, offset_i, wr_en_i, wr_addr_i, wr_data_i,
      input  dds_o, sample_vld_o, wrap_o
   );

   modport slave (
      input  en_i, wc_tick_i, len_i, gain_i, offset_i, wr_en_i, wr_addr_i, wr_data_i,
      output dds_o, sample_vld_o, wrap_o
   );
endinterface

// File: rtl/dds_sample_ram.sv
// Simple dual-port waveform RAM, synchronous read-first; shaped for block-RAM inference.
import dds_channel_pkg::*;

module dds_sample_ram (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // Non-blocking write means a same-address read returns the old word.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dds_channel.sv
// One DDS playback channel: tick-driven address counter, RAM read, gain/offset/saturate, DAC register.
import dds_channel_pkg::*;

module dds_channel (
   input  logic       sys_clk_i,
   input  logic       sys_rst_i,
   dds_channel_if.slave bus
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wrap_q, wrap_d;
   logic              vld1_q, vld1_d;
   logic              vld2_q, vld2_d;
   logic [DATA_W-1:0] res2_q, res2_d;
   logic [DATA_W-1:0] dds_q, dds_d;
   logic              svld_q, svld_d;
   logic              rd_en_c;
   logic [DATA_W-1:0] rd_data;

   assign rd_en_c = bus.en_i & bus.wc_tick_i;

   dds_sample_ram u_ram (
      .clk       (sys_clk_i),
      .wr_en_i   (bus.wr_en_i),
      .wr_addr_i (bus.wr_addr_i),
      .wr_data_i (bus.wr_data_i),
      .rd_en_i   (rd_en_c),
      .rd_addr_i (addr_q),
      .rd_data_o (rd_data)
   );

   // S1 = RAM read, S2 = scaled result, S3 = DAC code; disabling flushes the pipe.
   always_comb begin
      addr_d = addr_q;
      wrap_d = 1'b0;
      vld1_d = 1'b0;
      vld2_d = vld1_q;
      res2_d = res2_q;
      dds_d  = dds_q;
      svld_d = vld2_q;
      if (!bus.en_i) begin
         addr_d = '0;
         vld2_d = 1'b0;
         dds_d  = MID_CODE;
         svld_d = 1'b0;
      end else begin
         if (bus.wc_tick_i) begin
            vld1_d = 1'b1;
            // '>=' also catches len_i shrunk below the current address.
            if (addr_q >= bus.len_i) begin
               addr_d = '0;
               wrap_d = 1'b1;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         if (vld1_q) res2_d = scale_sample(rd_data, bus.gain_i, bus.offset_i);
         if (vld2_q) dds_d = res2_q;
      end
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         addr_q <= '0;
         wrap_q <= 1'b0;
         vld1_q <= 1'b0;
         vld2_q <= 1'b0;
         res2_q <= MID_CODE;
         dds_q  <= MID_CODE;
         svld_q <= 1'b0;
      end else begin
         addr_q <= addr_d;
         wrap_q <= wrap_d;
         vld1_q <= vld1_d;
         vld2_q <= vld2_d;
         res2_q <= res2_d;
         dds_q  <= dds_d;
         svld_q <= svld_d;
      end
   end

   assign bus.dds_o        = dds_q;
   assign bus.sample_vld_o = svld_q;
   assign bus.wrap_o       = wrap_q;

endmodule

// File: tb/tb_dds_channel.sv
// Directed bench for dds_channel: playback, scaling/saturation, back-to-back ticks, wrap, enable and reset.
module tb_dds_channel;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   dds_channel_if bus ();

   dds_channel u_dut (
      .sys_clk_i (clk),
      .sys_rst_i (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ram_wr(input int a, input int d);
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = 8'(a);
      bus.wr_data_i = 12'(d);
      step();
      bus.wr_en_i   = 1'b0;
   endtask

   task automatic tick();
      bus.wc_tick_i = 1'b1;
      step();
      bus.wc_tick_i = 1'b0;
   endtask

   task automatic en_toggle();
      bus.en_i = 1'b0;
      step();
      bus.en_i = 1'b1;
   endtask

   // One tick, then the sample must land two edges later as a single valid pulse.
   task automatic play_expect(input string tag, input int exp);
      tick();
      chk({tag, "_vld_early"}, 32'(bus.sample_vld_o), 32'd0);
      step();
      step();
      chk({tag, "_dds"}, 32'(bus.dds_o), 32'(exp));
      chk({tag, "_vld"}, 32'(bus.sample_vld_o), 32'd1);
      step();
   endtask

   initial begin
      int exp_seq [5];
      vectors     = 0;
      miscompares = 0;
      rst_n         = 1'b0;
      bus.en_i      = 1'b1;
      bus.wc_tick_i = 1'b0;
      bus.len_i     = '0;
      bus.gain_i    = 8'd128;
      bus.offset_i  = '0;
      bus.wr_en_i   = 1'b0;
      bus.wr_addr_i = '0;
      bus.wr_data_i = '0;

      // Reset state
      #12;
      chk("rst_dds", 32'(bus.dds_o), 32'd2048);
      chk("rst_vld", 32'(bus.sample_vld_o), 32'd0);
      chk("rst_wrap", 32'(bus.wrap_o), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // 1. RAM writes with no tick leave the output idle
      ram_wr(0, 2048);
      ram_wr(1, 3072);
      ram_wr(2, 1024);
      ram_wr(3, 4095);
      chk("t1_dds", 32'(bus.dds_o), 32'd2048);
      chk("t1_vld", 32'(bus.sample_vld_o), 32'd0);

      // 2. Unity playback, len 3, tick every 4 clocks
      bus.len_i = 8'd3;
      exp_seq = '{2048, 3072, 1024, 4095, 2048};
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("t2_wrap%0d", k), 32'(bus.wrap_o), (k == 3) ? 32'd1 : 32'd0);
         chk($sformatf("t2_vld_early%0d", k), 32'(bus.sample_vld_o), 32'd0);
         step();
         step();
         chk($sformatf("t2_dds%0d", k), 32'(bus.dds_o), 32'(exp_seq[k]));
         chk($sformatf("t2_vld%0d", k), 32'(bus.sample_vld_o), 32'd1);
         step();
         chk($sformatf("t2_hold%0d", k), 32'(bus.dds_o), 32'(exp_seq[k]));
         chk($sformatf("t2_vld_off%0d", k), 32'(bus.sample_vld_o), 32'd0);
      end

      // 3. Gain/offset and saturation
      en_toggle();
      ram_wr(0, 4095);
      ram_wr(1, 100);
      ram_wr(2, 3072);
      bus.len_i    = 8'd2;
      bus.gain_i   = 8'd255;
      bus.offset_i = 13'sd1000;
      play_expect("t3_sat_hi", 4095);
      bus.gain_i   = 8'd128;
      bus.offset_i = 13'h1000;
      play_expect("t3_sat_lo", 0);
      bus.gain_i   = 8'd64;
      bus.offset_i = '0;
      play_expect("t3_half", 2560);
      bus.gain_i   = 8'd128;

      // 4. Tick every cycle, len 1, alternating full-scale samples
      en_toggle();
      ram_wr(0, 0);
      ram_wr(1, 4095);
      bus.len_i     = 8'd1;
      bus.wc_tick_i = 1'b1;
      step();
      step();
      step();
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("t4_dds%0d", k), 32'(bus.dds_o), (k % 2 == 0) ? 32'd0 : 32'd4095);
         chk($sformatf("t4_vld%0d", k), 32'(bus.sample_vld_o), 32'd1);
         chk($sformatf("t4_wrap%0d", k), 32'(bus.wrap_o), (k % 2 == 1) ? 32'd1 : 32'd0);
         step();
      end
      bus.wc_tick_i = 1'b0;
      step();
      step();
      step();

      // 5. len shrunk below current address; read-first collision
      en_toggle();
      for (int i = 0; i < 10; i++) ram_wr(i, 1000 + 100 * i);
      bus.len_i     = 8'd9;
      bus.wc_tick_i = 1'b1;
      repeat (5) step();
      bus.wc_tick_i = 1'b0;
      step();
      step();
      step();
      bus.len_i = 8'd2;
      tick();
      chk("t5_wrap", 32'(bus.wrap_o), 32'd1);
      step();
      step();
      chk("t5_addr5", 32'(bus.dds_o), 32'd1500);
      step();
      play_expect("t5_addr0", 1000);
      bus.len_i = 8'd9;
      play_expect("t5_addr1", 1100);
      play_expect("t5_addr2", 1200);
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = 8'd3;
      bus.wr_data_i = 12'd77;
      bus.wc_tick_i = 1'b1;
      step();
      bus.wr_en_i   = 1'b0;
      bus.wc_tick_i = 1'b0;
      step();
      step();
      chk("t5_rdfirst", 32'(bus.dds_o), 32'd1300);
      step();
      en_toggle();
      play_expect("t5_r0", 1000);
      play_expect("t5_r1", 1100);
      play_expect("t5_r2", 1200);
      play_expect("t5_new3", 77);

      // 6. Enable dropped with two samples in flight
      bus.wc_tick_i = 1'b1;
      step();
      step();
      bus.en_i      = 1'b0;
      bus.wc_tick_i = 1'b0;
      step();
      chk("t6_dds", 32'(bus.dds_o), 32'd2048);
      chk("t6_vld", 32'(bus.sample_vld_o), 32'd0);
      step();
      chk("t6_vld1", 32'(bus.sample_vld_o), 32'd0);
      step();
      chk("t6_vld2", 32'(bus.sample_vld_o), 32'd0);
      chk("t6_dds2", 32'(bus.dds_o), 32'd2048);
      bus.en_i = 1'b1;

      // Async reset mid-stream
      bus.wc_tick_i = 1'b1;
      repeat (4) step();
      chk("t6_pre_rst_vld", 32'(bus.sample_vld_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_arst_dds", 32'(bus.dds_o), 32'd2048);
      chk("t6_arst_vld", 32'(bus.sample_vld_o), 32'd0);
      chk("t6_arst_wrap", 32'(bus.wrap_o), 32'd0);
      bus.wc_tick_i = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      play_expect("t6_post_rst", 1000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
